// File: rtl/bcrypt_cmp_if.sv
// bcrypt_cmp_if: bus between bcrypt_cmp and the logic around it.
// It carries two groups of signals:
//   - the config byte stream: cfg_start, din, wr_en, full
//   - the arbiter compare port: cmp_data, cmp_start, cmp_found,
//     cmp_finished, cmp_hash_num, ready, error
// master drives the requests (arbiter / config side).
// slave is the comparator.
interface bcrypt_cmp_if #(
    parameter int HASH_NUM_MSB = 8
);
    logic                  cfg_start;
    logic [7:0]            din;
    logic                  wr_en;
    logic                  full;
    logic [31:0]           cmp_data;
    logic                  cmp_start;
    logic                  cmp_found;
    logic                  cmp_finished;
    logic [HASH_NUM_MSB:0] cmp_hash_num;
    logic                  ready;
    logic [3:0]            error;

    modport master (
        output cfg_start, din, wr_en, cmp_data, cmp_start,
        input  full, cmp_found, cmp_finished, cmp_hash_num, ready, error
    );

    modport slave (
        input  cfg_start, din, wr_en, cmp_data, cmp_start,
        output full, cmp_found, cmp_finished, cmp_hash_num, ready, error
    );
endinterface

// File: rtl/bcrypt_cmp.sv
// bcrypt_cmp: partial-hash comparator beside bcrypt_arbiter.
//
// Holds up to 2^(HASH_NUM_MSB+1) 32-bit partial hashes, loaded from a byte
// stream as follows:
//   - count low byte, then count high byte
//   - then count x 4 bytes of little-endian hashes
// Each cmp_start accepted in READY searches the table for cmp_data.
// Every accepted search answers with exactly one pulse:
//   - cmp_found, with cmp_hash_num set to the matching index, or
//   - cmp_finished, when nothing matches.
//
// Ports:
//   CLK, rst        clock, synchronous active-high reset
//   bus (slave)     bcrypt_cmp_if:
//                     cfg_start/din/wr_en/full  config byte stream
//                     cmp_*/ready/error         arbiter compare port
//   error = {err_unsorted, err_overflow, err_busy, 1'b0}, all bits sticky.
//
// Build option BCRYPT_CMP_SORTED_EN:
//   - loaded hashes must be strictly ascending, otherwise err_unsorted is set;
//   - the search is a binary search instead of a linear scan.
// Without the macro err_unsorted is always 0.
module bcrypt_cmp #(
    parameter int HASH_NUM_MSB = 8
) (
    input  logic        CLK,
    input  logic        rst,
    bcrypt_cmp_if.slave bus
);
    localparam int          IDX_W    = HASH_NUM_MSB + 2;
    localparam int          AW       = HASH_NUM_MSB + 1;
    localparam int          DEPTH    = 1 << AW;
    localparam logic [15:0] DEPTH_16 = 16'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, LOAD_CNT0, LOAD_CNT1, LOAD_HASH,
        READY, SEARCH_RD, SEARCH_CMP, ERROR
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       cnt_lo_q, cnt_lo_nxt;
    logic [IDX_W-1:0] count_q, count_nxt;
    logic [1:0]       byte_q, byte_nxt;
    logic [IDX_W-1:0] widx_q, widx_nxt;
    logic [IDX_W-1:0] cmp_idx_p1, cmp_idx_nxt;
    logic             vld_p1, vld_nxt;
    logic             found_q, found_nxt;
    logic             finished_q, finished_nxt;
    logic [AW-1:0]    hash_num_q, hash_num_nxt;
    logic             err_overflow_q, err_overflow_nxt;
    logic             err_busy_q, err_busy_nxt;
    logic             err_unsorted;

`ifdef BCRYPT_CMP_SORTED_EN
    logic                    err_unsorted_q, err_unsorted_nxt;
    logic signed [IDX_W:0]   lo_q, lo_nxt, hi_q, hi_nxt;
    logic signed [IDX_W:0]   sum_c;
    logic        [IDX_W:0]   mid_c;
    logic        [31:0]      prev_q;
`else
    logic [IDX_W-1:0] rd_idx_q, rd_idx_nxt;
`endif

    // Table and datapath registers (not reset).
    logic [31:0] mem [DEPTH];
    logic [31:0] rd_data_p1;
    logic [31:0] key_p0;
    logic [23:0] wbuf_q;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [AW-1:0] rd_addr;
    logic          key_ld;
    logic          byte_ld;
    logic          full_c;
    logic          accept;
    logic          hit;
    logic [15:0]   cnt_full;

    assign full_c    = !(state == LOAD_CNT0 || state == LOAD_CNT1 || state == LOAD_HASH);
    assign accept    = bus.wr_en && !full_c;
    assign cnt_full  = {bus.din, cnt_lo_q};
    assign mem_wdata = {bus.din, wbuf_q};
    assign hit       = vld_p1 && (rd_data_p1 == key_p0);

    always_ff @(posedge CLK) begin
        if (rst) begin
            state          <= IDLE;
            cnt_lo_q       <= '0;
            count_q        <= '0;
            byte_q         <= '0;
            widx_q         <= '0;
            cmp_idx_p1     <= '0;
            vld_p1         <= 1'b0;
            found_q        <= 1'b0;
            finished_q     <= 1'b0;
            hash_num_q     <= '0;
            err_overflow_q <= 1'b0;
            err_busy_q     <= 1'b0;
`ifdef BCRYPT_CMP_SORTED_EN
            err_unsorted_q <= 1'b0;
            lo_q           <= '0;
            hi_q           <= '0;
`else
            rd_idx_q       <= '0;
`endif
        end else begin
            state          <= state_nxt;
            cnt_lo_q       <= cnt_lo_nxt;
            count_q        <= count_nxt;
            byte_q         <= byte_nxt;
            widx_q         <= widx_nxt;
            cmp_idx_p1     <= cmp_idx_nxt;
            vld_p1         <= vld_nxt;
            found_q        <= found_nxt;
            finished_q     <= finished_nxt;
            hash_num_q     <= hash_num_nxt;
            err_overflow_q <= err_overflow_nxt;
            err_busy_q     <= err_busy_nxt;
`ifdef BCRYPT_CMP_SORTED_EN
            err_unsorted_q <= err_unsorted_nxt;
            lo_q           <= lo_nxt;
            hi_q           <= hi_nxt;
`else
            rd_idx_q       <= rd_idx_nxt;
`endif
        end
    end

    // p0 -> p1: synchronous table read; write port used during load only.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        rd_data_p1 <= mem[rd_addr];
        if (key_ld) begin
            key_p0 <= bus.cmp_data;
        end
        if (byte_ld) begin
            case (byte_q)
                2'd0:    wbuf_q[7:0]   <= bus.din;
                2'd1:    wbuf_q[15:8]  <= bus.din;
                default: wbuf_q[23:16] <= bus.din;
            endcase
        end
`ifdef BCRYPT_CMP_SORTED_EN
        if (mem_we) begin
            prev_q <= mem_wdata;
        end
`endif
    end

`ifdef BCRYPT_CMP_SORTED_EN
    assign err_unsorted = err_unsorted_q;
    // lo+hi never exceeds 2*(depth-1), so the extra bit holds it without overflow.
    assign sum_c        = lo_q + hi_q;
    assign mid_c        = unsigned'(sum_c >>> 1);
`else
    assign err_unsorted = 1'b0;
`endif

    always_comb begin
        state_nxt        = state;
        cnt_lo_nxt       = cnt_lo_q;
        count_nxt        = count_q;
        byte_nxt         = byte_q;
        widx_nxt         = widx_q;
        cmp_idx_nxt      = cmp_idx_p1;
        vld_nxt          = 1'b0;
        found_nxt        = 1'b0;
        finished_nxt     = 1'b0;
        hash_num_nxt     = hash_num_q;
        err_overflow_nxt = err_overflow_q;
        err_busy_nxt     = err_busy_q;
        mem_we           = 1'b0;
        mem_waddr        = widx_q[AW-1:0];
        rd_addr          = '0;
        key_ld           = 1'b0;
        byte_ld          = 1'b0;
`ifdef BCRYPT_CMP_SORTED_EN
        err_unsorted_nxt = err_unsorted_q;
        lo_nxt           = lo_q;
        hi_nxt           = hi_q;
`else
        rd_idx_nxt       = rd_idx_q;
`endif

        case (state)
            LOAD_CNT0: begin
                if (accept) begin
                    cnt_lo_nxt = bus.din;
                    state_nxt  = LOAD_CNT1;
                end
            end
            LOAD_CNT1: begin
                if (accept) begin
                    if (cnt_full > DEPTH_16) begin
                        err_overflow_nxt = 1'b1;
                        state_nxt        = ERROR;
                    end else begin
                        count_nxt = cnt_full[IDX_W-1:0];
                        widx_nxt  = '0;
                        byte_nxt  = '0;
                        state_nxt = (cnt_full == 16'd0) ? READY : LOAD_HASH;
                    end
                end
            end
            LOAD_HASH: begin
                if (accept) begin
                    if (byte_q != 2'd3) begin
                        byte_ld  = 1'b1;
                        byte_nxt = byte_q + 2'd1;
                    end else begin
                        byte_nxt = '0;
`ifdef BCRYPT_CMP_SORTED_EN
                        if (widx_q != '0 && mem_wdata <= prev_q) begin
                            err_unsorted_nxt = 1'b1;
                            state_nxt        = ERROR;
                        end else
`endif
                        begin
                            mem_we   = 1'b1;
                            widx_nxt = widx_q + IDX_W'(1);
                            if (widx_q + IDX_W'(1) == count_q) begin
                                state_nxt = READY;
                            end
                        end
                    end
                end
            end
            READY: begin
                if (bus.cmp_start) begin
                    key_ld    = 1'b1;
                    state_nxt = SEARCH_RD;
`ifdef BCRYPT_CMP_SORTED_EN
                    lo_nxt = '0;
                    hi_nxt = $signed({1'b0, count_q}) - $signed((IDX_W + 1)'(1));
`endif
                end
            end
`ifdef BCRYPT_CMP_SORTED_EN
            SEARCH_RD: begin
                if (lo_q > hi_q) begin
                    finished_nxt = 1'b1;
                    state_nxt    = READY;
                end else begin
                    rd_addr     = mid_c[AW-1:0];
                    cmp_idx_nxt = mid_c[IDX_W-1:0];
                    vld_nxt     = 1'b1;
                    state_nxt   = SEARCH_CMP;
                end
            end
            SEARCH_CMP: begin
                if (hit) begin
                    found_nxt    = 1'b1;
                    hash_num_nxt = cmp_idx_p1[AW-1:0];
                    state_nxt    = READY;
                end else begin
                    if (key_p0 < rd_data_p1) begin
                        hi_nxt = $signed({1'b0, cmp_idx_p1}) - $signed((IDX_W + 1)'(1));
                    end else begin
                        lo_nxt = $signed({1'b0, cmp_idx_p1}) + $signed((IDX_W + 1)'(1));
                    end
                    state_nxt = SEARCH_RD;
                end
            end
`else
            SEARCH_RD: begin
                // Entry 0 is read here; an empty table answers right away.
                if (count_q == '0) begin
                    finished_nxt = 1'b1;
                    state_nxt    = READY;
                end else begin
                    rd_addr     = '0;
                    cmp_idx_nxt = '0;
                    rd_idx_nxt  = IDX_W'(1);
                    vld_nxt     = 1'b1;
                    state_nxt   = SEARCH_CMP;
                end
            end
            SEARCH_CMP: begin
                // Compare entry cmp_idx_p1 while the next entry is being read.
                if (hit) begin
                    found_nxt    = 1'b1;
                    hash_num_nxt = cmp_idx_p1[AW-1:0];
                    state_nxt    = READY;
                end else if (cmp_idx_p1 + IDX_W'(1) == count_q) begin
                    finished_nxt = 1'b1;
                    state_nxt    = READY;
                end else begin
                    rd_addr     = rd_idx_q[AW-1:0];
                    rd_idx_nxt  = rd_idx_q + IDX_W'(1);
                    cmp_idx_nxt = cmp_idx_p1 + IDX_W'(1);
                    vld_nxt     = 1'b1;
                end
            end
`endif
            default: ;
        endcase

        if (bus.cmp_start && state != READY) begin
            err_busy_nxt = 1'b1;
        end

        // A reload aborts any load or search silently; only rst leaves ERROR.
        if (bus.cfg_start && state != ERROR) begin
            state_nxt    = LOAD_CNT0;
            count_nxt    = '0;
            byte_nxt     = '0;
            widx_nxt     = '0;
            vld_nxt      = 1'b0;
            found_nxt    = 1'b0;
            finished_nxt = 1'b0;
            mem_we       = 1'b0;
            byte_ld      = 1'b0;
            key_ld       = 1'b0;
        end
    end

    assign bus.full         = full_c;
    assign bus.ready        = (state == READY);
    assign bus.cmp_found    = found_q;
    assign bus.cmp_finished = finished_q;
    assign bus.cmp_hash_num = hash_num_q;
    assign bus.error        = {err_unsorted, err_overflow_q, err_busy_q, 1'b0};
endmodule

// File: tb/tb_bcrypt_cmp.sv
// Testbench for bcrypt_cmp. Random tables and searches are checked every
// cycle against a behavioural model of the load protocol and the search
// result/latency; directed steps pin literal latencies and error bits.
module tb_bcrypt_cmp;
    localparam int MSB   = 8;
    localparam int DEPTH = 512;
    localparam int LIMIT = 2000;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    always #5 CLK = ~CLK;

    bcrypt_cmp_if #(.HASH_NUM_MSB(MSB)) bus ();
    bcrypt_cmp #(.HASH_NUM_MSB(MSB)) dut (.CLK(CLK), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_CNT0 = 1, M_CNT1 = 2, M_HASH = 3;
    localparam int M_READY = 4, M_SEARCH = 5, M_ERR = 6;

    int          m_mode = M_IDLE;
    int          m_cnt, m_widx, m_nb, m_resp_idx;
    logic [7:0]  m_lo;
    logic [7:0]  m_bytes [4];
    logic [31:0] m_tab [DEPTH];
    logic        m_busy, m_ovf, m_uns;
    longint      cyc = 0, m_resp_cyc;
    logic        e_found, e_fin;
    logic [MSB:0] e_num;
    logic        chk_en = 1'b0;

    // Expected (index, latency in cycles after cmp_start) of a search.
    function automatic void predict(input logic [31:0] key, output int idx, output int lat);
`ifdef BCRYPT_CMP_SORTED_EN
        int lo, hi, k, mid;
        bit done;
        lo = 0; hi = m_cnt - 1; k = 0; idx = -1; done = 0;
        while (!done && lo <= hi) begin
            k++;
            mid = (lo + hi) / 2;
            if (m_tab[mid] == key) begin idx = mid; done = 1; end
            else if (key < m_tab[mid]) hi = mid - 1;
            else lo = mid + 1;
        end
        lat = (idx >= 0) ? 2 * k + 1 : 2 * k + 2;
`else
        idx = -1;
        for (int i = m_cnt - 1; i >= 0; i--) if (m_tab[i] == key) idx = i;
        lat = (idx >= 0) ? idx + 3 : m_cnt + 2;
`endif
    endfunction

    always @(posedge CLK) begin
        int idx, lat, cnt16;
        logic [31:0] w;
        logic bad;
        if (rst) begin
            m_mode = M_IDLE; m_cnt = 0; m_busy = 0; m_ovf = 0; m_uns = 0;
            e_found = 0; e_fin = 0; e_num = '0;
        end else begin
            e_found = 0; e_fin = 0;
            if (bus.cmp_start && m_mode != M_READY) m_busy = 1;
            if (bus.cfg_start && m_mode != M_ERR) begin
                m_mode = M_CNT0; m_cnt = 0; m_nb = 0; m_widx = 0;
            end else begin
                case (m_mode)
                    M_CNT0: if (bus.wr_en) begin m_lo = bus.din; m_mode = M_CNT1; end
                    M_CNT1: if (bus.wr_en) begin
                        cnt16 = {16'd0, bus.din, m_lo};
                        if (cnt16 > DEPTH) begin m_ovf = 1; m_mode = M_ERR; end
                        else begin
                            m_cnt = cnt16; m_widx = 0; m_nb = 0;
                            m_mode = (cnt16 == 0) ? M_READY : M_HASH;
                        end
                    end
                    M_HASH: if (bus.wr_en) begin
                        m_bytes[m_nb] = bus.din;
                        m_nb++;
                        if (m_nb == 4) begin
                            m_nb = 0;
                            w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                            bad = 0;
`ifdef BCRYPT_CMP_SORTED_EN
                            bad = (m_widx > 0) && (w <= m_tab[m_widx - 1]);
`endif
                            if (bad) begin m_uns = 1; m_mode = M_ERR; end
                            else begin
                                m_tab[m_widx] = w;
                                m_widx++;
                                if (m_widx == m_cnt) m_mode = M_READY;
                            end
                        end
                    end
                    M_READY: if (bus.cmp_start) begin
                        predict(bus.cmp_data, idx, lat);
                        m_resp_idx = idx;
                        m_resp_cyc = cyc + lat;
                        m_mode = M_SEARCH;
                    end
                    M_SEARCH: if (cyc + 1 == m_resp_cyc) begin
                        if (m_resp_idx >= 0) begin e_found = 1; e_num = m_resp_idx[MSB:0]; end
                        else e_fin = 1;
                        m_mode = M_READY;
                    end
                    default: ;
                endcase
            end
        end
        cyc++;
    end

    // Compare process: all outputs, every cycle, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("cmp_found", bus.cmp_found, e_found);
            check("cmp_finished", bus.cmp_finished, e_fin);
            check("cmp_hash_num", bus.cmp_hash_num, e_num);
            check("ready", bus.ready, m_mode == M_READY);
            check("full", bus.full, !(m_mode == M_CNT0 || m_mode == M_CNT1 || m_mode == M_HASH));
            check("error", bus.error, {m_uns, m_ovf, m_busy, 1'b0});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        if ($urandom_range(3) == 0) step();
        bus.din = b; bus.wr_en = 1'b1; step(); bus.wr_en = 1'b0;
    endtask

    task automatic load(input int cnt, input logic [31:0] words[$]);
        bus.cfg_start = 1'b1; step(); bus.cfg_start = 1'b0;
        send_byte(cnt[7:0]);
        send_byte(cnt[15:8]);
        foreach (words[i]) for (int b = 0; b < 4; b++) send_byte(words[i][8*b +: 8]);
        step();
    endtask

    task automatic search(input logic [31:0] key, input bit stray,
                          output int lat, output logic fnd, output logic [MSB:0] num);
        bus.cmp_data = key; bus.cmp_start = 1'b1; step(); bus.cmp_start = 1'b0;
        lat = 1;
        while (!(bus.cmp_found || bus.cmp_finished) && lat < LIMIT) begin
            if (stray && lat == 2) begin bus.cmp_data = $urandom; bus.cmp_start = 1'b1; end
            step(); bus.cmp_start = 1'b0;
            lat++;
        end
        check("search_in_bound", lat < LIMIT, 1);
        fnd = bus.cmp_found;
        num = bus.cmp_hash_num;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q[$];
        logic [31:0] key;
        int lat;
        logic fnd;
        logic [MSB:0] num;

        bus.cfg_start = 0; bus.din = 0; bus.wr_en = 0; bus.cmp_data = 0; bus.cmp_start = 0;
        chk_en = 1'b1;
        rst = 1'b1; step(); step();
        check("rst_full", bus.full, 1);
        check("rst_ready", bus.ready, 0);
        check("rst_error", bus.error, 0);
        check("rst_hash_num", bus.cmp_hash_num, 0);
        rst = 1'b0; step();

`ifndef BCRYPT_CMP_SORTED_EN
        q = {32'h11111111, 32'hDEADBEEF, 32'h00000005};
        load(3, q);
        check("load3_ready", bus.ready, 1);
        check("load3_full", bus.full, 1);
        search(32'hDEADBEEF, 0, lat, fnd, num);
        check("hit_latency", lat, 4);
        check("hit_found", fnd, 1);
        check("hit_index", num, 1);
        search(32'h12345678, 0, lat, fnd, num);
        check("miss_latency", lat, 5);
        check("miss_found", fnd, 0);
        check("miss_index_held", num, 1);
        q.delete();
        load(0, q);
        check("empty_ready", bus.ready, 1);
        search(32'h0, 0, lat, fnd, num);
        check("empty_latency", lat, 2);
        check("empty_finished", bus.cmp_finished, 1);
`else
        q.delete();
        for (int i = 0; i < DEPTH; i++) q.push_back(32'(2 * i + 1));
        load(DEPTH, q);
        check("s512_ready", bus.ready, 1);
        search(32'(2 * (DEPTH - 1) + 1), 0, lat, fnd, num);
        check("s512_latency", lat <= 21, 1);
        check("s512_found", fnd, 1);
        check("s512_index", num, 511);
        q = {32'd5, 32'd3};
        load(2, q);
        check("unsorted_err", bus.error[3], 1);
        check("unsorted_ready", bus.ready, 0);
        rst = 1'b1; step(); rst = 1'b0;
        check("unsorted_rst_clear", bus.error, 0);
        step();
`endif

        // Abort: stray cmp_start mid-search, then cfg_start mid-search.
        q = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        load(5, q);
        bus.cmp_data = 32'd5; bus.cmp_start = 1'b1; step();
        bus.cmp_start = 1'b0; step();
        bus.cmp_data = 32'd3; bus.cmp_start = 1'b1; step();
        bus.cmp_start = 1'b0; bus.cfg_start = 1'b1; step();
        bus.cfg_start = 1'b0;
        check("abort_busy", bus.error[1], 1);
        repeat (6) begin
            check("abort_silent", bus.cmp_found | bus.cmp_finished, 0);
            step();
        end
        q = {32'h0000000A, 32'h0000000B};
        load(2, q);
        search(32'h0000000B, 0, lat, fnd, num);
`ifdef BCRYPT_CMP_SORTED_EN
        check("reload_latency", lat, 5);
`else
        check("reload_latency", lat, 4);
`endif
        check("reload_found", fnd, 1);
        check("reload_index", num, 1);

        // Overflow: 513 entries into a 512-deep table.
        q.delete();
        load(513, q);
        check("ovf_err", bus.error[2], 1);
        check("ovf_full", bus.full, 1);
        check("ovf_ready", bus.ready, 0);
        bus.cmp_start = 1'b1; step(); bus.cmp_start = 1'b0;
        repeat (8) begin
            check("ovf_silent", bus.cmp_found | bus.cmp_finished, 0);
            step();
        end
        rst = 1'b1; step(); rst = 1'b0;
        check("ovf_rst_clear", bus.error, 0);
        step();

        // Random tables and searches.
        for (int it = 0; it < 30; it++) begin
            int cnt;
            logic [31:0] v;
            q.delete();
            cnt = (it == 5) ? DEPTH : (($urandom_range(5) == 0) ? 0 : 32'($urandom_range(1, 24)));
            v = 32'($urandom_range(0, 3));
            for (int i = 0; i < cnt; i++) begin
`ifdef BCRYPT_CMP_SORTED_EN
                v = v + 32'($urandom_range(1, 3));
                q.push_back(v);
`else
                q.push_back(($urandom_range(3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 7)));
`endif
            end
            bus.din = 8'($urandom); bus.wr_en = 1'b1; step(); bus.wr_en = 1'b0;
            load(cnt, q);
            for (int s = 0; s < 6; s++) begin
                key = (cnt > 0 && $urandom_range(1) == 1) ? q[$urandom_range(cnt - 1)]
                                                          : 32'($urandom_range(0, 9));
                search(key, ($urandom_range(3) == 0), lat, fnd, num);
            end
        end

        step();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
